pipe_wb_writeback: RTL and testbench

//  MEM/WB pipeline register plus write-back stage of the dynamic pipeline CPU.

---
 rtl/pipe_wb_writeback.sv | 181 ++++++++++++++++++
 tb/tb_pipe_wb_writeback.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_wb_writeback.sv
// -----------------------------------------------------------------------------
// pipe_wb_writeback
//   MEM/WB pipeline register and write-back stage. Latches the MEM-stage
//   results, selects the register-file / HI / LO write data and drives the
//   write port consumed by the ID stage. A captured instruction writes exactly
//   once: enables are asserted only in the first cycle after capture (COMMIT);
//   a stall moves it to HOLD where data stays visible but nothing is written.
//   Also counts retired (committed) instructions.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   stall_i, flush_i         hold stage / capture a bubble (flush has priority)
//   valid_i                  MEM slot holds a real instruction
//   alu_i .. lo_i            MEM-stage result sources (product_i is 64 bits)
//   rd_select_i              0 link,1 alu,2 clz,3 hi,4 lo,5 dmem,6 cp0,7 product[31:0]
//   hi_select_i              0 zero,1 rs,2 product[63:32],3 remainder
//   lo_select_i              0 zero,1 rs,2 product[31:0],3 quotient
//   rf_waddr_i, *_wena_i     destination register and write intents
//   rf_*_o, hi_*_o, lo_*_o   write port to ID (enables are one-shot)
//   wb_valid_o               stage holds a valid instruction (COMMIT or HOLD)
//   retired_o                committed-instruction count, wraps modulo 2^RETIRE_W
// -----------------------------------------------------------------------------
module pipe_wb_writeback #(
   parameter int RETIRE_W = 32,
   parameter bit GUARD_R0 = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_i,
   input  logic                flush_i,
   input  logic                valid_i,
   input  logic [31:0]         alu_i,
   input  logic [31:0]         count_zeros_i,
   input  logic [31:0]         quotient_i,
   input  logic [31:0]         remainder_i,
   input  logic [63:0]         product_i,
   input  logic [31:0]         link_addr_i,
   input  logic [31:0]         cp0_rdata_i,
   input  logic [31:0]         dmem_rdata_i,
   input  logic [31:0]         rs_i,
   input  logic [31:0]         hi_i,
   input  logic [31:0]         lo_i,
   input  logic [2:0]          rd_select_i,
   input  logic [1:0]          hi_select_i,
   input  logic [1:0]          lo_select_i,
   input  logic [4:0]          rf_waddr_i,
   input  logic                rf_wena_i,
   input  logic                hi_wena_i,
   input  logic                lo_wena_i,
   output logic [31:0]         rf_wdata_o,
   output logic [4:0]          rf_waddr_o,
   output logic                rf_wena_o,
   output logic [31:0]         hi_wdata_o,
   output logic [31:0]         lo_wdata_o,
   output logic                hi_wena_o,
   output logic                lo_wena_o,
   output logic                wb_valid_o,
   output logic [RETIRE_W-1:0] retired_o
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      COMMIT = 2'd1,
      HOLD   = 2'd2
   } wb_state_t;

   wb_state_t             state_p1;
   logic [31:0]           alu_p1, clz_p1, quo_p1, rem_p1;
   logic [63:0]           prod_p1;
   logic [31:0]           link_p1, cp0_p1, dmem_p1, rs_p1, hi_p1, lo_p1;
   logic [2:0]            rd_sel_p1;
   logic [1:0]            hi_sel_p1, lo_sel_p1;
   logic [4:0]            waddr_p1;
   logic                  rf_wena_p1, hi_wena_p1, lo_wena_p1;
   logic [RETIRE_W-1:0]   retired_p1;

   function automatic logic [31:0] rd_mux(
      input logic [2:0]  sel,
      input logic [31:0] link, alu, clz, hi, lo, dmem, cp0,
      input logic [63:0] prod);
      case (sel)
         3'd0:    rd_mux = link;
         3'd1:    rd_mux = alu;
         3'd2:    rd_mux = clz;
         3'd3:    rd_mux = hi;
         3'd4:    rd_mux = lo;
         3'd5:    rd_mux = dmem;
         3'd6:    rd_mux = cp0;
         default: rd_mux = prod[31:0];
      endcase
   endfunction

   function automatic logic [31:0] hilo_mux(
      input logic [1:0]  sel,
      input logic [31:0] rs, prod_half, divres);
      case (sel)
         2'd0:    hilo_mux = 32'd0;
         2'd1:    hilo_mux = rs;
         2'd2:    hilo_mux = prod_half;
         default: hilo_mux = divres;
      endcase
   endfunction

   // ---- MEM/WB boundary: capture, hold or bubble ----
   // Enables are precomputed at capture so they are plain registers; they are
   // cleared on any edge that does not capture, which makes them one-shot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1   <= EMPTY;
         alu_p1     <= '0;
         clz_p1     <= '0;
         quo_p1     <= '0;
         rem_p1     <= '0;
         prod_p1    <= '0;
         link_p1    <= '0;
         cp0_p1     <= '0;
         dmem_p1    <= '0;
         rs_p1      <= '0;
         hi_p1      <= '0;
         lo_p1      <= '0;
         rd_sel_p1  <= '0;
         hi_sel_p1  <= '0;
         lo_sel_p1  <= '0;
         waddr_p1   <= '0;
         rf_wena_p1 <= 1'b0;
         hi_wena_p1 <= 1'b0;
         lo_wena_p1 <= 1'b0;
         retired_p1 <= '0;
      end else begin
         // Leaving COMMIT by any path retires the instruction.
         if (state_p1 == COMMIT)
            retired_p1 <= retired_p1 + 1'b1;

         if (flush_i) begin
            state_p1   <= EMPTY;
            rf_wena_p1 <= 1'b0;
            hi_wena_p1 <= 1'b0;
            lo_wena_p1 <= 1'b0;
         end else if (stall_i) begin
            if (state_p1 == COMMIT)
               state_p1 <= HOLD;
            rf_wena_p1 <= 1'b0;
            hi_wena_p1 <= 1'b0;
            lo_wena_p1 <= 1'b0;
         end else begin
            state_p1   <= valid_i ? COMMIT : EMPTY;
            alu_p1     <= alu_i;
            clz_p1     <= count_zeros_i;
            quo_p1     <= quotient_i;
            rem_p1     <= remainder_i;
            prod_p1    <= product_i;
            link_p1    <= link_addr_i;
            cp0_p1     <= cp0_rdata_i;
            dmem_p1    <= dmem_rdata_i;
            rs_p1      <= rs_i;
            hi_p1      <= hi_i;
            lo_p1      <= lo_i;
            rd_sel_p1  <= rd_select_i;
            hi_sel_p1  <= hi_select_i;
            lo_sel_p1  <= lo_select_i;
            waddr_p1   <= rf_waddr_i;
            rf_wena_p1 <= valid_i & rf_wena_i & ~(GUARD_R0 & (rf_waddr_i == 5'd0));
            hi_wena_p1 <= valid_i & hi_wena_i;
            lo_wena_p1 <= valid_i & lo_wena_i;
         end
      end
   end

   // ---- WB stage: data selection on latched fields ----
   assign rf_wdata_o = rd_mux(rd_sel_p1, link_p1, alu_p1, clz_p1, hi_p1, lo_p1,
                              dmem_p1, cp0_p1, prod_p1);
   assign hi_wdata_o = hilo_mux(hi_sel_p1, rs_p1, prod_p1[63:32], rem_p1);
   assign lo_wdata_o = hilo_mux(lo_sel_p1, rs_p1, prod_p1[31:0], quo_p1);
   assign rf_waddr_o = waddr_p1;
   assign rf_wena_o  = rf_wena_p1;
   assign hi_wena_o  = hi_wena_p1;
   assign lo_wena_o  = lo_wena_p1;
   assign wb_valid_o = (state_p1 != EMPTY);
   assign retired_o  = retired_p1;

endmodule

// File: tb/tb_pipe_wb_writeback.sv
module tb_pipe_wb_writeback;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [31:0] alu, clz, quo, rem;
      logic [63:0] prod;
      logic [31:0] link, cp0, dmem, rs, hi, lo;
      logic [2:0]  rd_sel;
      logic [1:0]  hi_sel, lo_sel;
      logic [4:0]  waddr;
      logic        rf_we, hi_we, lo_we;
   } ins_t;

   logic rst, stall, flush;
   ins_t in;

   logic [31:0] rf_wdata_a, hi_wdata_a, lo_wdata_a, ret_a;
   logic [4:0]  rf_waddr_a;
   logic        rf_we_a, hi_we_a, lo_we_a, vld_a;
   logic [31:0] rf_wdata_b, hi_wdata_b, lo_wdata_b;
   logic [3:0]  ret_b;
   logic [4:0]  rf_waddr_b;
   logic        rf_we_b, hi_we_b, lo_we_b, vld_b;

   pipe_wb_writeback #(.RETIRE_W(32), .GUARD_R0(1'b1)) dut_a (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .valid_i(in.valid),
      .alu_i(in.alu), .count_zeros_i(in.clz), .quotient_i(in.quo), .remainder_i(in.rem),
      .product_i(in.prod), .link_addr_i(in.link), .cp0_rdata_i(in.cp0),
      .dmem_rdata_i(in.dmem), .rs_i(in.rs), .hi_i(in.hi), .lo_i(in.lo),
      .rd_select_i(in.rd_sel), .hi_select_i(in.hi_sel), .lo_select_i(in.lo_sel),
      .rf_waddr_i(in.waddr), .rf_wena_i(in.rf_we), .hi_wena_i(in.hi_we), .lo_wena_i(in.lo_we),
      .rf_wdata_o(rf_wdata_a), .rf_waddr_o(rf_waddr_a), .rf_wena_o(rf_we_a),
      .hi_wdata_o(hi_wdata_a), .lo_wdata_o(lo_wdata_a), .hi_wena_o(hi_we_a),
      .lo_wena_o(lo_we_a), .wb_valid_o(vld_a), .retired_o(ret_a));

   pipe_wb_writeback #(.RETIRE_W(4), .GUARD_R0(1'b0)) dut_b (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .valid_i(in.valid),
      .alu_i(in.alu), .count_zeros_i(in.clz), .quotient_i(in.quo), .remainder_i(in.rem),
      .product_i(in.prod), .link_addr_i(in.link), .cp0_rdata_i(in.cp0),
      .dmem_rdata_i(in.dmem), .rs_i(in.rs), .hi_i(in.hi), .lo_i(in.lo),
      .rd_select_i(in.rd_sel), .hi_select_i(in.hi_sel), .lo_select_i(in.lo_sel),
      .rf_waddr_i(in.waddr), .rf_wena_i(in.rf_we), .hi_wena_i(in.hi_we), .lo_wena_i(in.lo_we),
      .rf_wdata_o(rf_wdata_b), .rf_waddr_o(rf_waddr_b), .rf_wena_o(rf_we_b),
      .hi_wdata_o(hi_wdata_b), .lo_wdata_o(lo_wdata_b), .hi_wena_o(hi_we_b),
      .lo_wena_o(lo_we_b), .wb_valid_o(vld_b), .retired_o(ret_b));

   int checks = 0;
   int failures = 0;

   // Reference model: the slot's captured instruction, whether it is present,
   // and whether it has already had its one write opportunity.
   ins_t        m_f;
   bit          m_valid, m_written;
   int unsigned m_ret;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input ins_t f);
      logic [31:0] srcs [8];
      srcs = '{f.link, f.alu, f.clz, f.hi, f.lo, f.dmem, f.cp0, f.prod[31:0]};
      return srcs[f.rd_sel];
   endfunction

   function automatic logic [31:0] exp_hi(input ins_t f);
      logic [31:0] srcs [4];
      srcs = '{32'd0, f.rs, f.prod[63:32], f.rem};
      return srcs[f.hi_sel];
   endfunction

   function automatic logic [31:0] exp_lo(input ins_t f);
      logic [31:0] srcs [4];
      srcs = '{32'd0, f.rs, f.prod[31:0], f.quo};
      return srcs[f.lo_sel];
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_f = '0; m_valid = 0; m_written = 0; m_ret = 0;
      end else begin
         // An instruction with its write still pending retires on this edge.
         if (m_valid && !m_written) m_ret++;
         if (m_valid) m_written = 1;
         if (flush) m_valid = 0;
         else if (!stall) begin
            m_f = in; m_valid = in.valid; m_written = 0;
         end
      end
   endtask

   task automatic check_all();
      bit writes;
      writes = m_valid && !m_written;
      chk("rf_wdata_a", rf_wdata_a, exp_rd(m_f));
      chk("rf_waddr_a", rf_waddr_a, m_f.waddr);
      chk("rf_wena_a", rf_we_a, writes && m_f.rf_we && m_f.waddr != 0);
      chk("hi_wdata_a", hi_wdata_a, exp_hi(m_f));
      chk("lo_wdata_a", lo_wdata_a, exp_lo(m_f));
      chk("hi_wena_a", hi_we_a, writes && m_f.hi_we);
      chk("lo_wena_a", lo_we_a, writes && m_f.lo_we);
      chk("wb_valid_a", vld_a, m_valid);
      chk("retired_a", ret_a, m_ret);
      chk("rf_wdata_b", rf_wdata_b, exp_rd(m_f));
      chk("rf_wena_b", rf_we_b, writes && m_f.rf_we);
      chk("hi_wdata_b", hi_wdata_b, exp_hi(m_f));
      chk("wb_valid_b", vld_b, m_valid);
      chk("retired_b", ret_b, m_ret % 16);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle();
      in = '0; stall = 0; flush = 0; rst = 0;
   endtask

   function automatic ins_t rand_ins();
      ins_t r;
      r.valid = $urandom_range(0, 3) != 0;
      r.alu = $urandom; r.clz = $urandom; r.quo = $urandom; r.rem = $urandom;
      r.prod = {$urandom, $urandom};
      r.link = $urandom; r.cp0 = $urandom; r.dmem = $urandom; r.rs = $urandom;
      r.hi = $urandom; r.lo = $urandom;
      r.rd_sel = 3'($urandom); r.hi_sel = 2'($urandom); r.lo_sel = 2'($urandom);
      r.waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      r.rf_we = 1'($urandom); r.hi_we = 1'($urandom); r.lo_we = 1'($urandom);
      return r;
   endfunction

   initial begin
      m_f = '0; m_valid = 0; m_written = 0; m_ret = 0;
      idle();
      rst = 1;
      step(); step();
      rst = 0;
      step();
      chk("t1_retired", ret_a, 32'd0);
      chk("t1_wdata", rf_wdata_a, 32'd0);

      // single ALU write
      in.valid = 1; in.rd_sel = 3'd1; in.alu = 32'h1234; in.waddr = 5'd5; in.rf_we = 1;
      step();
      chk("t2_wdata", rf_wdata_a, 32'h1234);
      chk("t2_waddr", rf_waddr_a, 5'd5);
      chk("t2_wena", rf_we_a, 1'b1);
      idle();
      step();
      chk("t2_wena_off", rf_we_a, 1'b0);
      chk("t2_retired", ret_a, 32'd1);

      // multiply result to HI/LO
      in.valid = 1; in.hi_sel = 2'd2; in.lo_sel = 2'd2; in.hi_we = 1; in.lo_we = 1;
      in.prod = 64'hAAAA0000_5555FFFF;
      step();
      chk("t3_hi", hi_wdata_a, 32'hAAAA0000);
      chk("t3_lo", lo_wdata_a, 32'h5555FFFF);
      chk("t3_hi_we", hi_we_a, 1'b1);
      chk("t3_lo_we", lo_we_a, 1'b1);
      idle();
      step();
      chk("t3_hi_we_off", hi_we_a, 1'b0);

      // stall holds data, writes once
      in.valid = 1; in.rd_sel = 3'd5; in.dmem = 32'hCAFE_F00D; in.waddr = 5'd7; in.rf_we = 1;
      step();
      chk("t4_wena_first", rf_we_a, 1'b1);
      in = rand_ins(); stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_wena_held", rf_we_a, 1'b0);
         chk("t4_data_held", rf_wdata_a, 32'hCAFE_F00D);
         chk("t4_valid_held", vld_a, 1'b1);
      end
      chk("t4_retired", ret_a, 32'd3);
      idle();
      step();

      // r0 guard, flush beats stall
      in.valid = 1; in.waddr = 5'd0; in.rf_we = 1; in.rd_sel = 3'd1; in.alu = 32'h55;
      step();
      chk("t5_r0_guard", rf_we_a, 1'b0);
      chk("t5_r0_noguard", rf_we_b, 1'b1);
      stall = 1; flush = 1;
      step();
      chk("t5_flush_valid", vld_a, 1'b0);
      idle();
      step();

      // 4-bit counter wraps after 16 commits; reset during COMMIT
      rst = 1; step(); rst = 0;
      for (int i = 0; i < 16; i++) begin
         in = rand_ins(); in.valid = 1;
         step();
      end
      idle();
      step();
      chk("t6_wrap_b", ret_b, 4'd0);
      chk("t6_count_a", ret_a, 32'd16);
      in.valid = 1; in.rf_we = 1; in.waddr = 5'd3;
      step();
      rst = 1;
      step();
      chk("t6_rst_count", ret_a, 32'd0);
      chk("t6_rst_wena", rf_we_a, 1'b0);
      idle();
      step();

      // randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         in    = rand_ins();
         stall = $urandom_range(0, 3) == 0;
         flush = $urandom_range(0, 9) == 0;
         rst   = $urandom_range(0, 49) == 0;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
